// File: rtl/controlador_barrido_display.sv
// Four-digit multiplexed display scanner with PWM brightness, blink and leading-zero blanking.
// Outputs are registered one clock after state; configuration is double-buffered and swaps at frame end.
module controlador_barrido_display #(
  parameter int P_DIV_PWM          = 6250,
  parameter int P_CUADROS_PARPADEO = 62
) (
  input  logic        i_Reloj,
  input  logic        i_Reset,
  input  logic [15:0] i_Datos,
  input  logic [3:0]  i_Habilitar,
  input  logic [3:0]  i_Brillo,
  input  logic [3:0]  i_Parpadeo,
  input  logic        i_Suprimir_Ceros,
  input  logic        i_Cargar,
  output logic [1:0]  o_Sel,
  output logic [3:0]  o_Dato,
  output logic [3:0]  o_Anodos,
  output logic        o_Fin_Cuadro,
  output logic        o_Ocupado
);

  localparam int W_PRE = (P_DIV_PWM > 1) ? $clog2(P_DIV_PWM) : 1;
  localparam int W_CUA = (P_CUADROS_PARPADEO > 1) ? $clog2(P_CUADROS_PARPADEO) : 1;
  localparam logic [W_PRE-1:0] PRE_MAX = W_PRE'(P_DIV_PWM - 1);
  localparam logic [W_CUA-1:0] CUA_MAX = W_CUA'(P_CUADROS_PARPADEO - 1);

  typedef struct packed {
    logic [15:0] datos;
    logic [3:0]  habilitar;
    logic [3:0]  brillo;
    logic [3:0]  parpadeo;
    logic        suprimir;
  } cfg_t;

  cfg_t             entrada;
  cfg_t             sombra;
  cfg_t             activa;
  cfg_t             activa_sig;
  logic [W_PRE-1:0] pre;
  logic [W_PRE-1:0] pre_sig;
  logic [3:0]       paso;
  logic [3:0]       paso_sig;
  logic [1:0]       sel_sig;
  logic [W_CUA-1:0] cuadro;
  logic [W_CUA-1:0] cuadro_sig;
  logic             fase;
  logic             fase_sig;
  logic             fin_ahora;
  logic             fin_sig;
  logic             transferir;
  logic [3:0]       ceros;
  logic             encender;
  logic [3:0]       anodos_sig;
  logic [3:0]       dato_sig;

  assign entrada = {i_Datos, i_Habilitar, i_Brillo, i_Parpadeo, i_Suprimir_Ceros};

  always_comb begin
    pre_sig    = pre + 1'b1;
    paso_sig   = paso;
    sel_sig    = o_Sel;
    cuadro_sig = cuadro;
    fase_sig   = fase;
    if (pre == PRE_MAX) begin
      pre_sig  = '0;
      paso_sig = paso + 4'd1;
      if (paso == 4'd15) begin
        sel_sig = o_Sel + 2'd1;
      end
    end

    fin_ahora = (o_Sel == 2'd3) && (paso == 4'd15) && (pre == PRE_MAX);
    // A load landing on the frame-end edge wins: the swap waits one more frame.
    transferir = fin_ahora && o_Ocupado && !i_Cargar;
    activa_sig = transferir ? sombra : activa;

    if (fin_ahora) begin
      if (cuadro == CUA_MAX) begin
        cuadro_sig = '0;
        fase_sig   = ~fase;
      end else begin
        cuadro_sig = cuadro + 1'b1;
      end
    end

    ceros    = 4'b0000;
    ceros[3] = (activa_sig.datos[15:12] == 4'd0);
    ceros[2] = ceros[3] && (activa_sig.datos[11:8] == 4'd0);
    ceros[1] = ceros[2] && (activa_sig.datos[7:4] == 4'd0);

    // Everything below is evaluated for the position the counters move to, so the
    // registered outputs line up with o_Sel in the same cycle.
    encender = activa_sig.habilitar[sel_sig]
            && (paso_sig < activa_sig.brillo)
            && !((paso_sig == 4'd0) && (pre_sig == '0))
            && !(fase_sig && activa_sig.parpadeo[sel_sig])
            && !(activa_sig.suprimir && ceros[sel_sig]);

    anodos_sig = encender ? ~(4'b0001 << sel_sig) : 4'b1111;
    dato_sig   = activa_sig.datos[{sel_sig, 2'b00} +: 4];
    fin_sig    = (sel_sig == 2'd3) && (paso_sig == 4'd15) && (pre_sig == PRE_MAX);
  end

  always_ff @(posedge i_Reloj) begin
    if (!i_Reset) begin
      pre          <= '0;
      paso         <= 4'd0;
      o_Sel        <= 2'd0;
      cuadro       <= '0;
      fase         <= 1'b0;
      sombra       <= '0;
      activa       <= '0;
      o_Ocupado    <= 1'b0;
      o_Anodos     <= 4'b1111;
      o_Dato       <= 4'd0;
      o_Fin_Cuadro <= 1'b0;
    end else begin
      pre          <= pre_sig;
      paso         <= paso_sig;
      o_Sel        <= sel_sig;
      cuadro       <= cuadro_sig;
      fase         <= fase_sig;
      activa       <= activa_sig;
      o_Anodos     <= anodos_sig;
      o_Dato       <= dato_sig;
      o_Fin_Cuadro <= fin_sig;
      if (i_Cargar) begin
        sombra    <= entrada;
        o_Ocupado <= 1'b1;
      end else if (transferir) begin
        o_Ocupado <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_controlador_barrido_display.sv
// Directed bench for the display scanner with a 32-clock slot and 128-clock frame.
module tb_controlador_barrido_display;

  logic        reloj = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] datos = 16'h0000;
  logic [3:0]  habilitar = 4'h0;
  logic [3:0]  brillo = 4'h0;
  logic [3:0]  parpadeo = 4'h0;
  logic        suprimir = 1'b0;
  logic        cargar = 1'b0;
  logic [1:0]  sel;
  logic [3:0]  dato;
  logic [3:0]  anodos;
  logic        fin_cuadro;
  logic        ocupado;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  controlador_barrido_display #(
    .P_DIV_PWM(2),
    .P_CUADROS_PARPADEO(2)
  ) dut (
    .i_Reloj(reloj),
    .i_Reset(reset),
    .i_Datos(datos),
    .i_Habilitar(habilitar),
    .i_Brillo(brillo),
    .i_Parpadeo(parpadeo),
    .i_Suprimir_Ceros(suprimir),
    .i_Cargar(cargar),
    .o_Sel(sel),
    .o_Dato(dato),
    .o_Anodos(anodos),
    .o_Fin_Cuadro(fin_cuadro),
    .o_Ocupado(ocupado)
  );

  always #5 reloj = ~reloj;

  task automatic comprobar(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge reloj);
    cyc++;
    @(negedge reloj);
  endtask

  task automatic cargar_cfg(input logic [15:0] d, input logic [3:0] h, input logic [3:0] b,
                            input logic [3:0] p, input logic s);
    datos = d; habilitar = h; brillo = b; parpadeo = p; suprimir = s;
    cargar = 1'b1;
    tick();
    cargar = 1'b0;
    // Scramble inputs: only the captured shadow may ever reach the display.
    datos = 16'hFFFF; habilitar = 4'hF; brillo = 4'hF; parpadeo = 4'hF; suprimir = 1'b0;
  endtask

  task automatic esperar_fin(input logic exp_ocup);
    int n;
    n = 0;
    while (fin_cuadro !== 1'b1 && n < 200) begin
      comprobar("ocupado_wait", 16'(ocupado), 16'(exp_ocup));
      tick();
      n++;
    end
    comprobar("fin_found", 16'(fin_cuadro), 16'd1);
  endtask

  task automatic comprobar_reset();
    comprobar("rst_anodos", 16'(anodos), 16'hF);
    comprobar("rst_sel", 16'(sel), 16'd0);
    comprobar("rst_dato", 16'(dato), 16'd0);
    comprobar("rst_fin", 16'(fin_cuadro), 16'd0);
    comprobar("rst_ocupado", 16'(ocupado), 16'd0);
  endtask

  // Called at clock 0 of a frame; walks all 128 clocks against a hand-given pattern.
  task automatic comprobar_cuadro(input logic [3:0] mask, input logic [15:0] d,
                                  input int ultimo, input logic exp_ocup);
    for (int i = 0; i < 128; i++) begin
      int dg;
      int c;
      logic [3:0] ea;
      dg = i / 32;
      c = i % 32;
      ea = 4'hF;
      if (mask[dg] && c >= 1 && c <= ultimo) ea = ~(4'b0001 << dg);
      comprobar("anodos", 16'(anodos), 16'(ea));
      comprobar("sel", 16'(sel), 16'(dg));
      comprobar("dato", 16'(dato), 16'(d[4*dg +: 4]));
      comprobar("fin", 16'(fin_cuadro), 16'(i == 127));
      comprobar("ocupado", 16'(ocupado), 16'(exp_ocup));
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    int fr;
    @(negedge reloj);
    reset = 1'b0;
    repeat (3) tick();
    comprobar_reset();
    reset = 1'b1;
    cyc = 0;

    // Idle after reset: dark, digit index every 32 clocks, frame pulse every 128.
    for (int i = 0; i < 300; i++) begin
      p = cyc % 128;
      comprobar("idle_anodos", 16'(anodos), 16'hF);
      comprobar("idle_sel", 16'(sel), 16'(p / 32));
      comprobar("idle_fin", 16'(fin_cuadro), 16'(p == 127));
      comprobar("idle_ocupado", 16'(ocupado), 16'd0);
      tick();
    end

    // Basic load, brightness 8: lit clocks 1..15 of each slot from the next frame.
    cargar_cfg(16'h1234, 4'hF, 4'd8, 4'h0, 1'b0);
    comprobar("load_ocupado", 16'(ocupado), 16'd1);
    esperar_fin(1'b1);
    comprobar("fin_ocupado", 16'(ocupado), 16'd1);
    tick();
    comprobar_cuadro(4'hF, 16'h1234, 15, 1'b0);

    // Load on the frame-end clock: shadow updates, swap waits a whole frame.
    esperar_fin(1'b0);
    cargar_cfg(16'h0050, 4'hF, 4'd15, 4'h0, 1'b1);
    comprobar_cuadro(4'hF, 16'h1234, 15, 1'b1);

    // Zero suppression with brightness 15: digits 3,2 dark, lit clocks 1..29.
    comprobar_cuadro(4'b0011, 16'h0050, 29, 1'b0);

    // Blink on digit 0; phase flips every two frames counted from reset.
    cargar_cfg(16'h1234, 4'hF, 4'd15, 4'b0001, 1'b0);
    esperar_fin(1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      fr = cyc / 128;
      comprobar_cuadro(((fr / 2) % 2 == 1) ? 4'b1110 : 4'b1111, 16'h1234, 29, 1'b0);
    end

    // Reset in the middle of the digit-2 slot with a load still pending.
    repeat (74) tick();
    comprobar("pre_rst_sel", 16'(sel), 16'd2);
    cargar_cfg(16'h8888, 4'hF, 4'd15, 4'h0, 1'b0);
    comprobar("pend_ocupado", 16'(ocupado), 16'd1);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    comprobar_reset();
    repeat (2) tick();
    comprobar_reset();
    reset = 1'b1;
    cyc = 0;
    comprobar_cuadro(4'h0, 16'h0000, 0, 1'b0);
    comprobar_cuadro(4'h0, 16'h0000, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controlador_barrido_display.md
CONTROLADOR_BARRIDO_DISPLAY -- requirements
Module: controlador_barrido_display

Interface
REQ-001 Parameter P_DIV_PWM, default 6250, SHALL set the number of clocks per PWM step (16 steps per digit slot; 100 MHz gives a 250 Hz frame).
REQ-002 Parameter P_CUADROS_PARPADEO, default 62, SHALL set the number of frames per blink half-period.
REQ-003 i_Reloj  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_Reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 i_Datos  input  16  SHALL carry 4 BCD/hex nibbles; [3:0] is digit 0, [15:12] is digit 3.
REQ-006 i_Habilitar  input  4  SHALL carry per-digit enables; 1 = digit may light.
REQ-007 i_Brillo  input  4  SHALL set brightness 0..15.
REQ-008 i_Parpadeo  input  4  SHALL carry per-digit blink enables.
REQ-009 i_Suprimir_Ceros  input  1  SHALL enable leading-zero blanking.
REQ-010 i_Cargar  input  1  SHALL be a one-cycle load strobe that captures all configuration inputs.
REQ-011 o_Sel  output  2  SHALL be the index of the digit currently scanned (drives the data mux).
REQ-012 o_Dato  output  4  SHALL be the active nibble of digit o_Sel.
REQ-013 o_Anodos  output  4  SHALL be the anode drives, active-low, one-hot-low or all high.
REQ-014 o_Fin_Cuadro  output  1  SHALL be a one-cycle end-of-frame pulse.
REQ-015 o_Ocupado  output  1  SHALL be high while a loaded configuration waits for transfer.

Function
REQ-016 Counters: the PWM prescaler SHALL count 0..P_DIV_PWM-1; the 4-bit PWM step SHALL advance on prescaler wrap; o_Sel SHALL advance on PWM step wrap 15->0, giving a slot of 16*P_DIV_PWM clocks; o_Sel SHALL wrap 3->0.
REQ-017 Registers: configuration SHALL be double-buffered with a shadow set and an active set; only the active set drives outputs.
REQ-018 i_Cargar SHALL write all inputs into the shadow set and set o_Ocupado on the next edge; a repeat i_Cargar SHALL overwrite the shadow set.
REQ-019 o_Fin_Cuadro SHALL be high exactly on the last clock of the digit-3 slot.
REQ-020 On the o_Fin_Cuadro edge with o_Ocupado=1, shadow SHALL copy to active and o_Ocupado SHALL clear; new values SHALL apply from the next digit-0 slot.
REQ-021 If i_Cargar coincides with o_Fin_Cuadro, the shadow SHALL be updated, the transfer SHALL be deferred to the next frame end, and o_Ocupado SHALL be 1 afterwards.
REQ-022 A digit SHALL be lit (o_Anodos[o_Sel]=0, others 1) iff all of the following hold:
  - enabled;
  - PWM step < brillo;
  - not the first clock of its slot (dead time);
  - not blanked by blink;
  - not blanked by zero suppression.
REQ-023 Brightness limits: brillo=0 SHALL keep the display dark; brillo=15 SHALL give a 15/16 duty less the one dead-time clock.
REQ-024 Blink: the phase bit SHALL toggle every P_CUADROS_PARPADEO frame ends (frame counter wraps); while phase=1, digits with their blink bit set SHALL be blanked.
REQ-025 Zero suppression: with suppression on, digit k (k=3..1) SHALL be blanked when its nibble and every higher nibble are 0; digit 0 SHALL never be suppressed.
REQ-026 o_Dato SHALL always present the active nibble for o_Sel, even when that digit is blanked.
REQ-027 All outputs SHALL be registered and combinationally independent of inputs.

Reset
REQ-028 While i_Reset=0 at an edge, the block SHALL load:
  - o_Anodos=4'b1111, o_Sel=0, o_Dato=0, o_Fin_Cuadro=0, o_Ocupado=0;
  - all counters and the blink phase = 0;
  - active and shadow sets = 0 (dark).
REQ-029 Reset mid-frame or mid-load SHALL discard any pending shadow; the scan SHALL restart at digit 0, step 0 on the first edge after release.

Verification (P_DIV_PWM=2, P_CUADROS_PARPADEO=2; slot 32 clocks, frame 128)
REQ-030 Reset, then idle 300 clocks -> o_Anodos=1111 throughout; o_Sel steps 0,1,2,3 every 32 clocks; o_Fin_Cuadro pulses every 128 clocks.
REQ-031 Load Datos=16'h1234, Habilitar=F, Brillo=8 -> o_Ocupado=1 until frame end; next frame, digit 0 lights with o_Dato=4 for clocks 1..15 of its slot and is dark for clock 0 and 16..31.
REQ-032 Load coincident with o_Fin_Cuadro -> no transfer that edge; o_Ocupado stays 1 for 128 more clocks, then the transfer occurs.
REQ-033 Datos=16'h0050, Suprimir=1, Brillo=15 -> digits 3 and 2 stay dark; digits 1 and 0 light with o_Dato 5 and 0.
REQ-034 Parpadeo=4'b0001 -> digit 0 dark during frames 2-3, lit during frames 4-5 (alternating 2-frame phases); other digits unaffected.
REQ-035 Reset asserted mid-slot of digit 2 with a pending load -> all outputs go to reset values; after release o_Ocupado=0 and the display stays dark.
